analizador_color: RTL and testbench
===================================

Name: analizador_color

Overview:
- Downstream consumer of the camera frame buffer: after a frame is captured, scans the buffer's RGB332 pixels through the buffer's read port.
- Classifies each pixel as red-, green- or blue-dominant, accumulates three counts and reports the frame's dominant colour with a one-cycle done pulse.
- Sits between the frame-buffer read port and the result/display logic; runs on the system clock, not PCLK.

Parameters:
- AW, 17: read address width; matches the capture side's write address.
- NPIX, 19200: pixels scanned per frame (addresses 0..NPIX-1).
- WIDTH, 160: pixels per line; used for x/y tracking.
- MIN_LVL, 3: minimum 3-bit channel value for a pixel to be classified.
- CW, 17: width of each per-colour counter; must satisfy 2^CW > NPIX.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE
- rd_addr  out  AW  frame-buffer read address
- rd_data  in  8  RGB332 pixel; synchronous RAM, valid one cycle after rd_addr
- busy  out  1  high from the start-sampling edge until done
- done  out  1  one-cycle pulse when results are valid
- color  out  2  0=none, 1=red, 2=green, 3=blue
- cnt_r, cnt_g, cnt_b  out  CW  per-colour pixel counts

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; rd_addr=0; busy=0; done=0; color=0; all counts=0; x/y counters=0; pipeline valid flag=0.
- FSM states: IDLE, SCAN, FLUSH, DECIDE, DONE.
  - IDLE: start=1 at an edge -> SCAN; rd_addr=0, busy=1, counts and color cleared.
  - SCAN: rd_addr increments by 1 per cycle. After issuing NPIX-1 -> FLUSH; rd_addr holds NPIX-1.
  - FLUSH: one cycle to consume the last returned pixel -> DECIDE.
  - DECIDE: register color -> DONE.
  - DONE: done=1 for exactly one cycle; busy=0 on the same edge; -> IDLE.
- Pipeline: a valid flag delayed one cycle from each issued address gates counting. Pixel k is classified at the edge after its data arrives.
- Latency: done is high in the cycle following edge N+3, where edge 0 is the start-sampling edge.
- Pixel decode:
  - R=D[7:5], G=D[4:2], B3={D[1:0],D[1]}.
  - Red if R>G, R>B3 and R>=MIN_LVL; analogous for green and blue.
  - Ties or below-threshold pixels are not counted.
- Decision:
  - Largest count wins.
  - Equal maxima resolve by priority red > green > blue.
  - If the winning count is 0, color=0.
- Results (color, counts) hold until the next accepted start.
- Boundaries:
  - start while busy is ignored; start held high re-triggers only after returning to IDLE.
  - Address never exceeds NPIX-1 (no wrap).
  - x wraps at WIDTH-1 and increments y.
  - Counts cannot overflow given the CW constraint.
  - Reset asserted mid-scan aborts immediately; no done pulse.

Optional Feature:
- Macro: ANALIZADOR_ROI_EN.
- Defined:
  - Adds inputs roi_x0, roi_x1 (8 bits each) and roi_y0, roi_y1 (7 bits each).
  - Only pixels with roi_x0<=x<=roi_x1 and roi_y0<=y<=roi_y1 are counted.
  - ROI inputs are latched at the start-sampling edge.
  - An empty ROI (x0>x1 or y0>y1) yields zero counts and color=0.
- Undefined: no ROI ports; every pixel is eligible; x/y counters may be optimised away.

Decomposition:
- Shared package/header:
  - colour codes: COLOR_NONE=0, COLOR_R=1, COLOR_G=2, COLOR_B=3.
  - FSM state encodings.
  - RGB332 field positions.
- Sub-module: clasificador_pixel, combinational. Takes 8-bit pixel and MIN_LVL; returns one-hot {is_r, is_g, is_b}. Reusable by other image stages.

Test Plan (NPIX=16, WIDTH=4, sync RAM model):
- All 16 pixels 0xE0 (R=7), start pulse -> rd_addr 0..15, done exactly 19 cycles after start edge; cnt_r=16, cnt_g=0, cnt_b=0, color=1.
- 8 pixels 0x1C (green) and 8 pixels 0x03 (blue) -> cnt_g=8, cnt_b=8, tie resolved color=2.
- All pixels 0x24 (R=1, G=1, B=0) -> no pixel classified, counts 0, color=0.
- start held high through the scan -> exactly one done pulse per pass, second scan begins only after IDLE; rst=0 at cycle 7 -> busy=0, counts 0, no done.
- ANALIZADOR_ROI_EN, ROI x 1..2, y 1..2, all pixels 0x03 -> cnt_b=4, color=3; ROI x0=3, x1=1 -> color=0.

Source files
------------

// File: rtl/analizador_color_pkg.sv
// rtl/analizador_color_pkg.sv - shared colour codes, FSM states and RGB332 field layout
package analizador_color_pkg;

  localparam logic [1:0] COLOR_NONE = 2'd0;
  localparam logic [1:0] COLOR_R    = 2'd1;
  localparam logic [1:0] COLOR_G    = 2'd2;
  localparam logic [1:0] COLOR_B    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLUSH,
    ST_DECIDE,
    ST_DONE
  } state_t;

  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Blue has only two bits; replicating the MSB spans the same 0..7 range as R and G.
  function automatic logic [2:0] expand_b(input logic [1:0] b);
    return {b, b[1]};
  endfunction

endpackage

// File: rtl/analizador_color_if.sv
// rtl/analizador_color_if.sv - frame-buffer read port and result bus; ANALIZADOR_ROI_EN adds ROI inputs
interface analizador_color_if #(
  parameter int AW = 17,
  parameter int CW = 17
);
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic [1:0]    color;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_g;
  logic [CW-1:0] cnt_b;
`ifdef ANALIZADOR_ROI_EN
  logic [7:0]    roi_x0;
  logic [7:0]    roi_x1;
  logic [6:0]    roi_y0;
  logic [6:0]    roi_y1;
`endif

  modport master (
    input  start, rd_data,
`ifdef ANALIZADOR_ROI_EN
    input  roi_x0, roi_x1, roi_y0, roi_y1,
`endif
    output rd_addr, busy, done, color, cnt_r, cnt_g, cnt_b
  );

  modport slave (
    output start, rd_data,
`ifdef ANALIZADOR_ROI_EN
    output roi_x0, roi_x1, roi_y0, roi_y1,
`endif
    input  rd_addr, busy, done, color, cnt_r, cnt_g, cnt_b
  );

endinterface

// File: rtl/analizador_color_clasificador_pixel.sv
// rtl/analizador_color_clasificador_pixel.sv - combinational RGB332 dominant-channel classifier
module clasificador_pixel
  import analizador_color_pkg::*;
#(
  parameter logic [2:0] MIN_LVL = 3'd3
) (
  input  logic [7:0] i_pixel,
  output logic       o_is_r,
  output logic       o_is_g,
  output logic       o_is_b
);

  logic [2:0] w_r;
  logic [2:0] w_g;
  logic [2:0] w_b;

  assign w_r = i_pixel[R_MSB:R_LSB];
  assign w_g = i_pixel[G_MSB:G_LSB];
  assign w_b = expand_b(i_pixel[B_MSB:B_LSB]);

  // Strict comparisons: any tie for the top value leaves the pixel unclassified.
  assign o_is_r = (w_r > w_g) && (w_r > w_b) && (w_r >= MIN_LVL);
  assign o_is_g = (w_g > w_r) && (w_g > w_b) && (w_g >= MIN_LVL);
  assign o_is_b = (w_b > w_r) && (w_b > w_g) && (w_b >= MIN_LVL);

endmodule

// File: rtl/analizador_color.sv
// rtl/analizador_color.sv - frame colour analyser; ANALIZADOR_ROI_EN restricts counting to a latched ROI
module analizador_color
  import analizador_color_pkg::*;
#(
  parameter int AW      = 17,
  parameter int NPIX    = 19200,
  parameter int WIDTH   = 160,
  parameter int MIN_LVL = 3,
  parameter int CW      = 17
) (
  input logic                i_clk,
  input logic                i_rst,
  analizador_color_if.master bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_t        r_state;
  logic [AW-1:0] r_rd_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_vld;
  logic [1:0]    r_color;
  logic [CW-1:0] r_cnt_r;
  logic [CW-1:0] r_cnt_g;
  logic [CW-1:0] r_cnt_b;

  logic w_is_r;
  logic w_is_g;
  logic w_is_b;
  logic w_in_roi;

  clasificador_pixel #(
    .MIN_LVL (3'(MIN_LVL))
  ) u_clasificador (
    .i_pixel (bus.rd_data),
    .o_is_r  (w_is_r),
    .o_is_g  (w_is_g),
    .o_is_b  (w_is_b)
  );

`ifdef ANALIZADOR_ROI_EN
  localparam logic [7:0] LAST_X = 8'(WIDTH - 1);

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [7:0] r_roi_x0;
  logic [7:0] r_roi_x1;
  logic [6:0] r_roi_y0;
  logic [6:0] r_roi_y1;

  assign w_in_roi = (r_x >= r_roi_x0) && (r_x <= r_roi_x1) &&
                    (r_y >= r_roi_y0) && (r_y <= r_roi_y1);

  // x/y follow the pixel currently being classified, not the address being issued.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_roi_x0 <= '0;
      r_roi_x1 <= '0;
      r_roi_y0 <= '0;
      r_roi_y1 <= '0;
    end else if (r_state == ST_IDLE && bus.start) begin
      r_x      <= '0;
      r_y      <= '0;
      r_roi_x0 <= bus.roi_x0;
      r_roi_x1 <= bus.roi_x1;
      r_roi_y0 <= bus.roi_y0;
      r_roi_y1 <= bus.roi_y1;
    end else if (r_vld) begin
      if (r_x == LAST_X) begin
        r_x <= '0;
        r_y <= r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end
`else
  logic w_unused_geom;
  assign w_unused_geom = WIDTH[0];
  assign w_in_roi      = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_vld     <= 1'b0;
      r_color   <= COLOR_NONE;
      r_cnt_r   <= '0;
      r_cnt_g   <= '0;
      r_cnt_b   <= '0;
    end else begin
      r_done <= 1'b0;
      r_vld  <= (r_state == ST_SCAN);

      if (r_vld && w_in_roi) begin
        if (w_is_r) r_cnt_r <= r_cnt_r + CW'(1);
        if (w_is_g) r_cnt_g <= r_cnt_g + CW'(1);
        if (w_is_b) r_cnt_b <= r_cnt_b + CW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_SCAN;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
            r_color   <= COLOR_NONE;
            r_cnt_r   <= '0;
            r_cnt_g   <= '0;
            r_cnt_b   <= '0;
          end
        end
        ST_SCAN: begin
          if (r_rd_addr == LAST_ADDR) begin
            r_state <= ST_FLUSH;
          end else begin
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          // Red wins ties against both, green wins ties against blue.
          if (r_cnt_r >= r_cnt_g && r_cnt_r >= r_cnt_b) begin
            r_color <= (r_cnt_r == '0) ? COLOR_NONE : COLOR_R;
          end else if (r_cnt_g >= r_cnt_b) begin
            r_color <= COLOR_G;
          end else begin
            r_color <= COLOR_B;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_addr = r_rd_addr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.color   = r_color;
  assign bus.cnt_r   = r_cnt_r;
  assign bus.cnt_g   = r_cnt_g;
  assign bus.cnt_b   = r_cnt_b;

endmodule

// File: tb/tb_analizador_color.sv
// tb/tb_analizador_color.sv - scoreboard bench for analizador_color; ANALIZADOR_ROI_EN enables ROI vectors
module tb_analizador_color;
  import analizador_color_pkg::*;

  localparam int AW    = 17;
  localparam int NPIX  = 16;
  localparam int WIDTH = 4;
  localparam int CW    = 17;

  typedef struct {
    string      name;
    logic [1:0] color;
    int         cr;
    int         cg;
    int         cb;
    int         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   addr_viol = 0;
  exp_t sb[$];
  logic [7:0] mem [NPIX];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  analizador_color_if #(.AW(AW), .CW(CW)) bus ();

  analizador_color #(
    .AW(AW), .NPIX(NPIX), .WIDTH(WIDTH), .MIN_LVL(3), .CW(CW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr[3:0]];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rd_addr > AW'(NPIX - 1)) addr_viol++;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_color"},   bus.color, e.color);
        check({e.name, "_cnt_r"},   bus.cnt_r, e.cr);
        check({e.name, "_cnt_g"},   bus.cnt_g, e.cg);
        check({e.name, "_cnt_b"},   bus.cnt_b, e.cb);
        check({e.name, "_latency"}, cyc, e.cyc);
        check({e.name, "_busy"},    bus.busy, 0);
      end
    end
  end

  task automatic fill(input int n, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < NPIX; i++) mem[i] = (i < n) ? a : b;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check({name, "_timeout"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run(input string name, input logic [1:0] col,
                     input int cr, input int cg, input int cb, input bit chk_addr);
    exp_t e;
    @(negedge clk);
    e.name = name; e.color = col; e.cr = cr; e.cg = cg; e.cb = cb;
    e.cyc  = cyc + NPIX + 4;
    sb.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (chk_addr) begin
      check({name, "_busy_on"}, bus.busy, 1);
      for (int k = 0; k <= NPIX; k++) begin
        check({name, "_addr"}, bus.rd_addr, (k < NPIX) ? k : NPIX - 1);
        @(negedge clk);
      end
    end
    wait_drain(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    exp_t e1, e2;
    bus.start = 1'b0;
`ifdef ANALIZADOR_ROI_EN
    bus.roi_x0 = 8'd0;  bus.roi_x1 = 8'd255;
    bus.roi_y0 = 7'd0;  bus.roi_y1 = 7'd127;
`endif
    fill(NPIX, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    check("rst_color", bus.color, COLOR_NONE);
    check("rst_addr",  bus.rd_addr, 0);
    check("rst_cnt_r", bus.cnt_r, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill(NPIX, 8'hE0, 8'hE0);
    run("all_red", COLOR_R, 16, 0, 0, 1'b1);

    fill(8, 8'h1C, 8'h03);
    run("tie_gb", COLOR_G, 0, 8, 8, 1'b0);
    repeat (5) @(negedge clk);
    check("hold_color", bus.color, COLOR_G);
    check("hold_cnt_g", bus.cnt_g, 8);

    fill(NPIX, 8'h24, 8'h24);
    run("none", COLOR_NONE, 0, 0, 0, 1'b0);

    fill(10, 8'h60, 8'h40);
    run("min_lvl", COLOR_R, 10, 0, 0, 1'b0);

    fill(5, 8'hE0, 8'h03);
    run("blue_wins", COLOR_B, 5, 0, 11, 1'b0);

    // start held high: one done per pass, re-trigger only from IDLE
    fill(NPIX, 8'hE0, 8'hE0);
    @(negedge clk);
    e1.name = "held1"; e1.color = COLOR_R; e1.cr = 16; e1.cg = 0; e1.cb = 0;
    e1.cyc  = cyc + NPIX + 4;
    e2 = e1;
    e2.name = "held2";
    e2.cyc  = cyc + 2 * (NPIX + 4);
    sb.push_back(e1);
    sb.push_back(e2);
    bus.start = 1'b1;
    repeat (25) @(negedge clk);
    bus.start = 1'b0;
    wait_drain("held");
    repeat (30) @(negedge clk);
    check("held_idle_busy", bus.busy, 0);

    // reset mid-scan
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_cnt_r_pre", bus.cnt_r, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  bus.busy, 0);
    check("mid_rst_cnt_r", bus.cnt_r, 0);
    check("mid_rst_addr",  bus.rd_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst_no_scan", bus.busy, 0);

`ifdef ANALIZADOR_ROI_EN
    fill(NPIX, 8'h03, 8'h03);
    bus.roi_x0 = 8'd1; bus.roi_x1 = 8'd2;
    bus.roi_y0 = 7'd1; bus.roi_y1 = 7'd2;
    run("roi_box", COLOR_B, 0, 0, 4, 1'b0);
    bus.roi_x0 = 8'd3; bus.roi_x1 = 8'd1;
    run("roi_empty", COLOR_NONE, 0, 0, 0, 1'b0);
`endif

    check("addr_bound", addr_viol, 0);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
